// File: rtl/message_uart_pkg.sv
// Shared types for the message UART transmitter: the FSM state encoding and the
// clocks-per-bit calculation.
package message_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    function automatic int calc_cpb(input int clock_rate, input int baud_rate);
        return clock_rate / baud_rate;
    endfunction

endpackage

// File: rtl/message_uart_tx_if.sv
// Block RAM read port: the transmitter presents raddr, the RAM returns rdata
// one cycle later.
interface message_uart_tx_if #(
    parameter int addr_bits = 11
);
    logic [addr_bits-1:0] raddr;
    logic [7:0]           rdata;

    modport master (output raddr, input  rdata);
    modport slave  (input  raddr, output rdata);
endinterface

// File: rtl/message_uart_tx_serializer.sv
// 8N1 frame serializer: accepts one byte on valid/ready and shifts it out as
// start bit, 8 data bits LSB first and a stop bit, each CPB cycles long.
module uart_tx_serializer
    import message_uart_pkg::*;
#(
    parameter int CPB = 4
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_last,
    output logic       o_ser_tx
);

    localparam int            CW      = $clog2(CPB);
    localparam logic [CW-1:0] CNT_MAX = CW'(CPB - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_ser_tx;
    logic          w_bit_end;

    assign w_bit_end = (r_cnt == CNT_MAX);
    assign o_ready   = (r_state == IDLE);
    // NOTE: o_last is combinational so the owner can schedule its next fetch on
    // the same edge that ends the stop bit, keeping the inter-frame gap at 2 cycles.
    assign o_last    = (r_state == STOP) && w_bit_end;
    assign o_ser_tx  = r_ser_tx;

    // NOTE: reset is synchronous, so it lives inside the clocked block and every
    // state register is assigned with <= only.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_ser_tx <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ser_tx <= 1'b1;
                    if (i_valid) begin
                        r_shift  <= i_data;
                        r_cnt    <= '0;
                        r_bit    <= '0;
                        r_ser_tx <= 1'b0;
                        r_state  <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_cnt    <= '0;
                        r_ser_tx <= r_shift[0];
                        r_shift  <= {1'b0, r_shift[7:1]};
                        r_state  <= DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) begin
                            r_ser_tx <= 1'b1;
                            r_state  <= STOP;
                        end else begin
                            r_ser_tx <= r_shift[0];
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_bit    <= r_bit + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_ser_tx <= 1'b1;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/message_uart_tx.sv
// Streams a zero-terminated message from block RAM out of ser_tx as 8N1 frames.
// Optional host flow control on ser_rts_n is enabled with MESSAGE_UART_TX_CTS_EN.
module message_uart_tx
    import message_uart_pkg::*;
#(
    parameter int clock_rate = 24000000,
    parameter int baud_rate  = 1200,
    parameter int depth      = 1152,
    parameter int addr_bits  = $clog2(depth)
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     start,
    message_uart_tx_if.master        ram,
    output logic                     ser_tx,
    input  logic                     ser_rts_n,
    output logic                     busy,
    output logic                     done
);

    localparam int                   CPB       = calc_cpb(clock_rate, baud_rate);
    localparam logic [addr_bits-1:0] LAST_ADDR = addr_bits'(depth - 1);

    generate
        if (CPB < 2) begin : g_cpb_check
            $error("message_uart_tx: clock_rate / baud_rate must be at least 2");
        end
    endgenerate

    state_t               r_state;
    logic [addr_bits-1:0] r_raddr;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_ready;
    logic                 w_last;
    logic                 w_cts_ok;
    logic                 w_valid;

`ifdef MESSAGE_UART_TX_CTS_EN
    assign w_cts_ok = ~ser_rts_n;
`else
    logic w_unused_rts;
    assign w_unused_rts = ser_rts_n;
    assign w_cts_ok     = 1'b1;
`endif

    assign w_valid   = (r_state == LOAD) && (ram.rdata != 8'h00) && w_cts_ok && w_ready;
    assign ram.raddr = r_raddr;
    assign busy      = r_busy;
    assign done      = r_done;

    // START here stands for the whole frame, which the serializer owns until o_last.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= IDLE;
            r_raddr <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                FETCH: r_state <= LOAD;
                LOAD: begin
                    if (ram.rdata == 8'h00) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_raddr <= '0;
                        r_state <= IDLE;
                    end else if (w_valid) begin
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_last) begin
                        if (r_raddr == LAST_ADDR) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_raddr <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_raddr <= r_raddr + 1'b1;
                            r_state <= FETCH;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    uart_tx_serializer #(
        .CPB (CPB)
    ) u_serializer (
        .CLK      (CLK),
        .reset    (reset),
        .i_valid  (w_valid),
        .i_data   (ram.rdata),
        .o_ready  (w_ready),
        .o_last   (w_last),
        .o_ser_tx (ser_tx)
    );

endmodule

// File: tb/tb_message_uart_tx.sv
// Scoreboard bench for message_uart_tx: bytes expected on the line are queued when
// start is driven and popped as a bit-level receiver decodes each frame.
module tb_message_uart_tx;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic CLK = 1'b0;
    logic reset;
    logic start;
    logic ser_tx;
    logic ser_rts_n;
    logic busy;
    logic done;

    logic [7:0] mem [0:DEPTH-1];
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    message_uart_tx_if #(.addr_bits(AW)) bus ();

    message_uart_tx #(
        .clock_rate (40),
        .baud_rate  (10),
        .depth      (DEPTH),
        .addr_bits  (AW)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .start     (start),
        .ram       (bus),
        .ser_tx    (ser_tx),
        .ser_rts_n (ser_rts_n),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    // Synchronous RAM with one cycle of read latency.
    always @(posedge CLK) bus.rdata <= mem[bus.raddr];

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Pulse start and decode the line cycle by cycle. second_k re-pulses start
    // after cycle second_k; rts_k holds ser_rts_n high until cycle rts_k.
    task automatic run_message(input int second_k, input int rts_k);
        int   n = 0;
        bit   term = 0;
        int   done_k = 0;
        int   n_done = 0;
        int   n_frames = 0;
        int   max_ra = 0;
        int   fs = 0;
        int   exp_fs;
        int   exp_done;
        int   rel;
        bit   in_frame = 0;
        bit   idle_bad = 0;
        logic [7:0] sh = '0;

        for (int a = 0; a < DEPTH; a++) begin
            if (mem[a] == 8'h00) begin
                term = 1;
                break;
            end
            exp_q.push_back(mem[a]);
            n++;
        end
        exp_fs = (rts_k > 0) ? rts_k + 1 : 3;

        @(negedge CLK);
        start = 1'b1;
        if (rts_k > 0) ser_rts_n = 1'b1;

        for (int k = 1; k <= 400; k++) begin
            @(negedge CLK);
            if (int'(bus.raddr) > max_ra) max_ra = int'(bus.raddr);
            if (k == 1) check("busy_after_start", busy, 1);
            if (done_k != 0) begin
                if (ser_tx !== 1'b1 || busy !== 1'b0) idle_bad = 1;
            end else if (!in_frame && ser_tx == 1'b0) begin
                in_frame = 1;
                fs = k;
                check("frame_start_cycle", fs, exp_fs);
                check("raddr_during_frame", int'(bus.raddr), n_frames);
                exp_fs = fs + 42;
            end else if (in_frame) begin
                rel = k - fs;
                if (rel >= 6 && rel <= 34 && (rel % 4) == 2) sh = {ser_tx, sh[7:1]};
                if (rel == 38) begin
                    check("stop_bit", ser_tx, 1);
                    check("frame_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) check("rx_byte", sh, exp_q.pop_front());
                    n_frames++;
                end
                if (rel == 39) in_frame = 0;
            end
            if (done == 1'b1) begin
                n_done++;
                if (done_k == 0) begin
                    done_k = k;
                    check("busy_low_with_done", busy, 0);
                    check("raddr_wrapped", int'(bus.raddr), 0);
                end
            end
            start = (k == second_k);
            if (k == rts_k) ser_rts_n = 1'b0;
            if (done_k != 0 && k >= done_k + 12) break;
        end
        start = 1'b0;

        exp_done = (term ? 3 + 42 * n : 1 + 42 * n) + ((rts_k > 0) ? rts_k - 2 : 0);
        check("done_cycle", done_k, exp_done);
        check("done_pulse_count", n_done, 1);
        check("frame_count", n_frames, n);
        check("raddr_max", max_ra, term ? n : DEPTH - 1);
        check("idle_after_done", idle_bad, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        bit bad;
        reset     = 1'b1;
        start     = 1'b0;
        ser_rts_n = 1'b0;
        for (int a = 0; a < DEPTH; a++) mem[a] = 8'h00;

        // Reset held for 3 cycles, then released.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("rst_ser_tx", ser_tx, 1);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_raddr", int'(bus.raddr), 0);
        end
        reset = 1'b0;
        @(negedge CLK);
        check("post_rst_ser_tx", ser_tx, 1);
        check("post_rst_busy", busy, 0);

        // "Hi" followed by a terminator.
        mem[0] = 8'h48; mem[1] = 8'h69; mem[2] = 8'h00; mem[3] = 8'h7E;
        run_message(0, 0);

        // No terminator: scan stops at the last RAM word.
        for (int a = 0; a < DEPTH; a++) mem[a] = 8'h55;
        run_message(0, 0);

        // Empty message with a second start pulse while busy.
        mem[0] = 8'h00;
        run_message(1, 0);

        // Reset in the 3rd cycle of data bit 4 of a 0x41 frame.
        for (int a = 0; a < DEPTH; a++) mem[a] = 8'h41;
        @(negedge CLK);
        start = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge CLK);
            start = 1'b0;
        end
        check("bit4_level", ser_tx, 0);
        reset = 1'b1;
        @(negedge CLK);
        check("abort_ser_tx", ser_tx, 1);
        check("abort_busy", busy, 0);
        check("abort_raddr", int'(bus.raddr), 0);
        check("abort_done", done, 0);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if (done !== 1'b0 || ser_tx !== 1'b1) bad = 1;
        end
        check("quiet_after_abort", bad, 0);

`ifdef MESSAGE_UART_TX_CTS_EN
        // Host not ready for 20 cycles, then ready.
        mem[0] = 8'h5A; mem[1] = 8'h00;
        run_message(0, 20);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
